// File: rtl/eth_rx_filter_if.sv
// Stream bundle between the MAC RX side, eth_rx_filter and eth_decap.
// master = environment (drives RX beats, eth_filt_tready); slave = eth_rx_filter.
interface eth_rx_filter_if;
  logic        eth_rx_tvalid;
  logic [63:0] eth_rx_tdata;
  logic [7:0]  eth_rx_tkeep;
  logic        eth_rx_tlast;
  logic        eth_rx_tuser;
  logic        eth_filt_tvalid;
  logic        eth_filt_tready;
  logic [63:0] eth_filt_tdata;
  logic [7:0]  eth_filt_tkeep;
  logic        eth_filt_tlast;

  modport master (
    output eth_rx_tvalid, eth_rx_tdata, eth_rx_tkeep, eth_rx_tlast, eth_rx_tuser, eth_filt_tready,
    input  eth_filt_tvalid, eth_filt_tdata, eth_filt_tkeep, eth_filt_tlast
  );

  modport slave (
    input  eth_rx_tvalid, eth_rx_tdata, eth_rx_tkeep, eth_rx_tlast, eth_rx_tuser, eth_filt_tready,
    output eth_filt_tvalid, eth_filt_tdata, eth_filt_tkeep, eth_filt_tlast
  );
endinterface

// File: rtl/eth_rx_filter.sv
// Ethernet/IPv4/UDP ingress filter with store-and-forward buffer and pointer rollback.
// Optional ETH_RX_FILTER_STATS_EN adds per-frame accept/drop counters.
module eth_rx_filter #(
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter logic [15:0] PORT_MASK  = 16'hff00
) (
  input  logic           eth_clk,
  input  logic           eth_rst_n,
  eth_rx_filter_if.slave bus,
  input  logic [47:0]    adapter_reg_srcmac,
  input  logic [31:0]    adapter_reg_srcip,
  input  logic [15:0]    adapter_reg_srcport
`ifdef ETH_RX_FILTER_STATS_EN
  ,
  output logic [31:0]    stat_accept,
  output logic [31:0]    stat_drop_filter,
  output logic [31:0]    stat_drop_err,
  output logic [31:0]    stat_drop_ovf
`endif
);

  localparam int unsigned DW    = 64;
  localparam int unsigned KW    = 8;
  localparam int unsigned EW    = DW + KW + 1;
  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned BW    = 3;

  typedef enum logic {ST_SYNC, ST_RUN} state_e;

  state_e        r_state, w_state_nxt;
  logic [AW-1:0] r_wr_ptr, r_commit_ptr, r_rd_ptr;
  logic [BW-1:0] r_bcnt;
  logic          r_ok, r_ovf;
  logic [EW-1:0] r_mem [DEPTH];
  logic [EW-1:0] r_ram_q, r_out, r_skid;
  logic          r_rd_vld, r_vld;
  logic [1:0]    r_cnt;

  logic [DW-1:0] w_d;
  logic          w_beat, w_full, w_ovf_now, w_write, w_chk, w_ok, w_short, w_err, w_end, w_accept;
  logic          w_pop, w_issue;
  logic [2:0]    w_occ;

  assign w_d = bus.eth_rx_tdata;

  // Frame alignment: discard everything up to and including the first tlast after reset
  always_ff @(posedge eth_clk or negedge eth_rst_n) begin
    if (!eth_rst_n) r_state <= ST_SYNC;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_SYNC && bus.eth_rx_tvalid && bus.eth_rx_tlast) w_state_nxt = ST_RUN;
  end

  // Per-beat header field checks (wire byte n sits in lane n%8 of beat n/8)
  always_comb begin
    w_chk = 1'b1;
    case (r_bcnt)
      3'd0: w_chk = {w_d[7:0], w_d[15:8], w_d[23:16], w_d[31:24], w_d[39:32], w_d[47:40]}
                    == adapter_reg_srcmac;
      3'd1: w_chk = ({w_d[39:32], w_d[47:40]} == 16'h0800) && (w_d[55:48] == 8'h45);
      3'd2: w_chk = (w_d[63:56] == 8'h11);
      3'd3: w_chk = ({w_d[55:48], w_d[63:56]} == adapter_reg_srcip[31:16]);
      3'd4: w_chk = ({w_d[7:0], w_d[15:8]} == adapter_reg_srcip[15:0]) &&
                    (({w_d[39:32], w_d[47:40]} & PORT_MASK) == (adapter_reg_srcport & PORT_MASK));
      default: w_chk = 1'b1;
    endcase
  end

  always_comb begin
    w_beat    = bus.eth_rx_tvalid && (r_state == ST_RUN);
    w_full    = ((r_wr_ptr + AW'(1)) == r_rd_ptr);
    w_ovf_now = r_ovf || w_full;
    w_write   = w_beat && !w_ovf_now;
    w_ok      = ((r_bcnt == '0) || r_ok) && w_chk;
    w_short   = (r_bcnt < BW'(4));
    w_err     = bus.eth_rx_tuser || w_short;
    w_end     = w_beat && bus.eth_rx_tlast;
    w_accept  = w_end && !w_ovf_now && !w_err && w_ok;
  end

  // Write side: commit or roll back the frame on its tlast beat
  always_ff @(posedge eth_clk or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_bcnt       <= '0;
      r_ok         <= 1'b0;
      r_ovf        <= 1'b0;
    end else if (w_beat) begin
      if (bus.eth_rx_tlast) begin
        r_bcnt <= '0;
        r_ok   <= 1'b0;
        r_ovf  <= 1'b0;
        if (w_accept) begin
          r_wr_ptr     <= r_wr_ptr + AW'(1);
          r_commit_ptr <= r_wr_ptr + AW'(1);
        end else begin
          r_wr_ptr <= r_commit_ptr;
        end
      end else begin
        r_bcnt <= (r_bcnt == BW'(7)) ? r_bcnt : r_bcnt + BW'(1);
        r_ok   <= w_ok;
        r_ovf  <= w_ovf_now;
        if (w_write) r_wr_ptr <= r_wr_ptr + AW'(1);
      end
    end
  end

  // Frame buffer with registered read port
  always_ff @(posedge eth_clk) begin
    if (w_write) r_mem[r_wr_ptr] <= {bus.eth_rx_tlast, bus.eth_rx_tkeep, bus.eth_rx_tdata};
    if (w_issue) r_ram_q <= r_mem[r_rd_ptr];
  end

  // Issue a read only if the output pair can absorb it after this cycle's pop
  always_comb begin
    w_pop   = r_vld && bus.eth_filt_tready;
    w_occ   = 3'(r_cnt) + 3'(r_rd_vld) - 3'(w_pop);
    w_issue = (r_rd_ptr != r_commit_ptr) && (w_occ < 3'd2);
  end

  always_ff @(posedge eth_clk or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      r_rd_ptr <= '0;
      r_rd_vld <= 1'b0;
      r_cnt    <= 2'd0;
      r_vld    <= 1'b0;
      r_out    <= '0;
      r_skid   <= '0;
    end else begin
      r_rd_vld <= w_issue;
      if (w_issue) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({r_rd_vld, w_pop})
        2'b10: begin
          r_vld <= 1'b1;
          if (r_cnt == 2'd0) begin
            r_out <= r_ram_q;
            r_cnt <= 2'd1;
          end else begin
            r_skid <= r_ram_q;
            r_cnt  <= 2'd2;
          end
        end
        2'b01: begin
          r_out <= r_skid;
          r_cnt <= r_cnt - 2'd1;
          r_vld <= (r_cnt == 2'd2);
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_out <= r_ram_q;
          end else begin
            r_out  <= r_skid;
            r_skid <= r_ram_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.eth_filt_tvalid = r_vld;
  assign bus.eth_filt_tlast  = r_out[EW-1];
  assign bus.eth_filt_tkeep  = r_out[DW +: KW];
  assign bus.eth_filt_tdata  = r_out[DW-1:0];

`ifdef ETH_RX_FILTER_STATS_EN
  // One counter per frame, priority overflow > error/short > filter
  always_ff @(posedge eth_clk or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      stat_accept      <= '0;
      stat_drop_filter <= '0;
      stat_drop_err    <= '0;
      stat_drop_ovf    <= '0;
    end else if (w_end) begin
      if (w_ovf_now)  stat_drop_ovf    <= stat_drop_ovf + 32'd1;
      else if (w_err) stat_drop_err    <= stat_drop_err + 32'd1;
      else if (!w_ok) stat_drop_filter <= stat_drop_filter + 32'd1;
      else            stat_accept      <= stat_accept + 32'd1;
    end
  end
`endif

endmodule
